// File: rtl/gpr_cdb_arbiter_pkg.sv
// rtl/gpr_cdb_arbiter_pkg.sv - shared CDB types, requester ids and helpers
//
// Purpose: common definitions for the GPR common-data-bus arbiter and its
//          users (reservation stations, ROB, functional units).
// Contents:
//   ROB_WIDTH, XLEN     tag and data widths carried on the CDB
//   cdb_t               broadcast record {valid, tag, data}
//   gpr_cdb_req_t       requester slot assignment on the GPR CDB
//   N_GPR_CDB_REQ       number of GPR CDB requesters
//   tag_match()         valid-qualified tag compare used by snoopers
//   idx_width()         index width for an N-entry selector (min 1)

package gpr_cdb_arbiter_pkg;

    localparam int ROB_WIDTH = 6;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [XLEN-1:0]      data;
    } cdb_t;

    typedef enum logic [1:0] {
        REQ_ADD_SUB = 2'd0,
        REQ_MOV     = 2'd1,
        REQ_BRANCH  = 2'd2,
        REQ_LOAD    = 2'd3
    } gpr_cdb_req_t;

    localparam int N_GPR_CDB_REQ = 4;

    // Tag/data on the bus are meaningless unless valid is set.
    function automatic logic tag_match(input cdb_t cdb, input logic [ROB_WIDTH-1:0] tag);
        return cdb.valid && (cdb.tag == tag);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpr_cdb_arbiter_if.sv
// rtl/gpr_cdb_arbiter_if.sv - request/grant and broadcast bundle of the GPR CDB arbiter
//
// Purpose: groups the per-unit handshake, unit results and the CDB broadcast.
// Signals:
//   req_valid    [N_REQ]       unit i has a dispatchable entry
//   req_ready    [N_REQ]       grant, one-hot or zero
//   unit_result  cdb_t[N_REQ]  registered result of each unit (.valid ignored)
//   gpr_cdb      cdb_t         broadcast onto the common data bus
//   grant_idx_q  [IDX_W]       unit currently driving gpr_cdb
// Modports:
//   slave   arbiter side
//   master  functional-unit / consumer side

interface gpr_cdb_arbiter_if
    import gpr_cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = N_GPR_CDB_REQ
);
    localparam int IDX_W = idx_width(N_REQ);

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    cdb_t             unit_result [N_REQ];
    cdb_t             gpr_cdb;
    logic [IDX_W-1:0] grant_idx_q;

    modport slave (
        input  req_valid,
        input  unit_result,
        output req_ready,
        output gpr_cdb,
        output grant_idx_q
    );

    modport master (
        output req_valid,
        output unit_result,
        input  req_ready,
        input  gpr_cdb,
        input  grant_idx_q
    );

endinterface

// File: rtl/gpr_cdb_arbiter_rr_pick.sv
// rtl/gpr_cdb_arbiter_rr_pick.sv - first-valid picker scanning upward from a start pointer
//
// Purpose: returns the first set bit of valid found scanning ptr, ptr+1, ...,
//          N-1, 0, ... (mod N). With ptr tied to 0 it is a plain lowest-index
//          priority picker. Purely combinational.
// Ports:
//   valid   in  [N]      candidate requests
//   ptr     in  [IDX_W]  scan start, must be < N
//   onehot  out [N]      selected request, zero when none
//   idx     out [IDX_W]  index of the selected request (0 when none)
//   any     out 1        some request selected

module gpr_cdb_arbiter_rr_pick
    import gpr_cdb_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin : scan
        int j;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            // Wrap by subtraction so non-power-of-2 N never indexes past N-1.
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && valid[j]) begin
                any       = 1'b1;
                idx       = IDX_W'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_cdb_arbiter.sv
// rtl/gpr_cdb_arbiter.sv - single-grant arbiter and broadcast mux for the GPR CDB
//
// Purpose: grants at most one functional unit per cycle. Units whose
//          FIXED_PRIO bit is set (the load unit, which cannot stall) win over
//          all others, lowest index first; the rest share round-robin. The
//          granted unit registers its result at the next edge and the arbiter
//          places that result on gpr_cdb during the following cycle.
// Ports:
//   clk    in  1        clock
//   reset  in  1        synchronous, active-high
//   bus    slave        req_valid/req_ready, unit_result, gpr_cdb, grant_idx_q

module gpr_cdb_arbiter
    import gpr_cdb_arbiter_pkg::*;
#(
    parameter int               N_REQ      = N_GPR_CDB_REQ,
    parameter logic [N_REQ-1:0] FIXED_PRIO = {1'b1, {(N_REQ-1){1'b0}}}
) (
    input  logic             clk,
    input  logic             reset,
    gpr_cdb_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(N_REQ);

    logic [IDX_W-1:0] rr_ptr;
    logic             grant_any_q;
    logic [IDX_W-1:0] grant_idx_q;

    logic [N_REQ-1:0] fix_onehot;
    logic [IDX_W-1:0] fix_idx;
    logic             fix_any;
    logic [N_REQ-1:0] rr_onehot;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_any;

    logic [N_REQ-1:0] win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic [IDX_W-1:0] rr_ptr_next;

    // Fixed-priority class: lowest index wins, so the scan always starts at 0.
    gpr_cdb_arbiter_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_fix_pick (
        .valid  (bus.req_valid & FIXED_PRIO),
        .ptr    ({IDX_W{1'b0}}),
        .onehot (fix_onehot),
        .idx    (fix_idx),
        .any    (fix_any)
    );

    gpr_cdb_arbiter_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid  (bus.req_valid & ~FIXED_PRIO),
        .ptr    (rr_ptr),
        .onehot (rr_onehot),
        .idx    (rr_idx),
        .any    (rr_any)
    );

    always_comb begin
        win_onehot = rr_onehot;
        win_idx    = rr_idx;
        if (fix_any) begin
            win_onehot = fix_onehot;
            win_idx    = fix_idx;
        end
        win_any = fix_any | rr_any;
    end

    // Pointer moves just past the round-robin winner, wrapping explicitly.
    assign rr_ptr_next = (rr_idx == IDX_W'(N_REQ - 1)) ? '0 : rr_idx + 1'b1;

    // Units share this reset, so no one may dispatch while it is asserted.
    assign bus.req_ready = reset ? '0 : win_onehot;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            grant_any_q <= 1'b0;
            grant_idx_q <= '0;
        end else begin
            grant_any_q <= win_any;
            if (win_any) begin
                grant_idx_q <= win_idx;
            end
            // A fixed-priority win must not disturb the fairness rotation.
            if (!fix_any && rr_any) begin
                rr_ptr <= rr_ptr_next;
            end
        end
    end

    always_comb begin
        bus.gpr_cdb       = bus.unit_result[grant_idx_q];
        bus.gpr_cdb.valid = grant_any_q;
    end

    assign bus.grant_idx_q = grant_idx_q;

endmodule

// File: tb/tb_gpr_cdb_arbiter.sv
// tb/tb_gpr_cdb_arbiter.sv - scoreboard bench for gpr_cdb_arbiter (N=4 fixed load, N=3 pure rr)

module tb_gpr_cdb_arbiter;
    import gpr_cdb_arbiter_pkg::*;

    localparam logic [3:0] FIX4 = 4'b1000;
    localparam logic [3:0] FIX3 = 4'b0000;

    typedef struct {
        logic valid;
        int   idx;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gpr_cdb_arbiter_if #(.N_REQ(4)) bus4 ();
    gpr_cdb_arbiter_if #(.N_REQ(3)) bus3 ();

    gpr_cdb_arbiter #(.N_REQ(4), .FIXED_PRIO(4'b1000)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    gpr_cdb_arbiter #(.N_REQ(3), .FIXED_PRIO(3'b000)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t q4[$];
    exp_t q3[$];
    int   ptr4 = 0, ptr3 = 0, gidx4 = 0, gidx3 = 0;
    logic state_known = 1'b0;
    logic dp_on = 1'b0;
    cdb_t drv4 [4];
    cdb_t drv3 [3];
    cdb_t seen4;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic cdb_t mk_res(input int c, input int i);
        cdb_t r;
        r.valid = 1'b0;
        r.tag   = ROB_WIDTH'(c * 5 + i);
        r.data  = {16'(c), 16'(i)} ^ 32'h5A5A_0000;
        return r;
    endfunction

    function automatic int pick(input logic [3:0] v, input int ptr, input int n, input logic [3:0] fixed);
        for (int i = 0; i < n; i++) begin
            if (v[i] && fixed[i]) return i;
        end
        for (int k = 0; k < n; k++) begin
            int j;
            j = (ptr + k) % n;
            if (v[j] && !fixed[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int g);
        logic [3:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // eg4/eg3: expected grant index from the directed plan (-1 none, -2 use model)
    task automatic cycle(input logic rst, input logic [3:0] v4, input logic [2:0] v3,
                         input int eg4, input int eg3);
        int   g4, g3;
        exp_t e;
        @(negedge clk);
        reset          = rst;
        bus4.req_valid = v4;
        bus3.req_valid = v3;
        for (int i = 0; i < 4; i++) begin
            drv4[i] = mk_res(cyc, i);
            if (dp_on && i == 1) begin
                drv4[i].tag  = ROB_WIDTH'(5);
                drv4[i].data = 32'hDEAD_BEEF;
            end
            bus4.unit_result[i] = drv4[i];
        end
        for (int i = 0; i < 3; i++) begin
            drv3[i]             = mk_res(cyc, i + 8);
            bus3.unit_result[i] = drv3[i];
        end
        #1;
        seen4 = bus4.gpr_cdb;

        if (q4.size() > 0) begin
            e = q4.pop_front();
            if (!rst) begin
                check("cdb4_valid", 64'(bus4.gpr_cdb.valid), 64'(e.valid));
                if (e.valid) begin
                    check("cdb4_tag", 64'(bus4.gpr_cdb.tag), 64'(drv4[e.idx].tag));
                    check("cdb4_data", 64'(bus4.gpr_cdb.data), 64'(drv4[e.idx].data));
                end
            end
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            if (!rst) begin
                check("cdb3_valid", 64'(bus3.gpr_cdb.valid), 64'(e.valid));
                if (e.valid) begin
                    check("cdb3_tag", 64'(bus3.gpr_cdb.tag), 64'(drv3[e.idx].tag));
                    check("cdb3_data", 64'(bus3.gpr_cdb.data), 64'(drv3[e.idx].data));
                end
            end
        end

        g4 = (eg4 != -2) ? eg4 : pick(v4, ptr4, 4, FIX4);
        g3 = (eg3 != -2) ? eg3 : pick({1'b0, v3}, ptr3, 3, FIX3);
        if (rst) begin
            g4 = -1;
            g3 = -1;
        end
        check("ready4", 64'(bus4.req_ready), 64'(onehot(g4)));
        check("ready3", 64'(bus3.req_ready), 64'(onehot(g3)));
        if (state_known) begin
            check("gidx4", 64'(bus4.grant_idx_q), 64'(gidx4));
            check("gidx3", 64'(bus3.grant_idx_q), 64'(gidx3));
            check("rrptr4", 64'(dut4.rr_ptr), 64'(ptr4));
            check("rrptr3", 64'(dut3.rr_ptr), 64'(ptr3));
        end

        if (rst) begin
            ptr4 = 0; gidx4 = 0; ptr3 = 0; gidx3 = 0;
            q4.push_back('{valid: 1'b0, idx: 0});
            q3.push_back('{valid: 1'b0, idx: 0});
        end else begin
            q4.push_back('{valid: (g4 >= 0), idx: (g4 >= 0) ? g4 : 0});
            q3.push_back('{valid: (g3 >= 0), idx: (g3 >= 0) ? g3 : 0});
            if (g4 >= 0) begin
                gidx4 = g4;
                if (!FIX4[g4]) ptr4 = (g4 + 1) % 4;
            end
            if (g3 >= 0) begin
                gidx3 = g3;
                if (!FIX3[g3]) ptr3 = (g3 + 1) % 3;
            end
        end
        @(posedge clk);
        state_known = 1'b1;
        cyc++;
    endtask

    initial begin
        int rr4 [6];
        int rr3 [6];
        logic [2:0] v3s [6];
        rr4 = '{0, 1, 2, 0, 1, 2};
        rr3 = '{1, 2, 0, 2, -1, -1};
        v3s = '{3'b010, 3'b101, 3'b101, 3'b101, 3'b000, 3'b000};

        reset = 1'b1;
        bus4.req_valid = '0;
        bus3.req_valid = '0;

        cycle(1'b1, 4'b0000, 3'b000, -1, -1);
        cycle(1'b1, 4'b0000, 3'b000, -1, -1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 3'b000, -1, -1);

        // Round-robin on dut4; wrap through rr_ptr=2 on dut3.
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0111, v3s[i], rr4[i], rr3[i]);

        // Fixed priority: load unit wins three times, pointer untouched.
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1011, 3'b000, 3, -1);
        cycle(1'b0, 4'b0011, 3'b000, 0, -1);
        cycle(1'b0, 4'b0011, 3'b000, 1, -1);

        // Data path: grant unit 1, then it presents {5, DEADBEEF}.
        cycle(1'b0, 4'b0010, 3'b000, 1, -1);
        dp_on = 1'b1;
        cycle(1'b0, 4'b0000, 3'b000, -1, -1);
        dp_on = 1'b0;
        check("dp_valid", 64'(seen4.valid), 64'(1'b1));
        check("dp_tag", 64'(seen4.tag), 64'(5));
        check("dp_data", 64'(seen4.data), 64'h0000_0000_DEAD_BEEF);
        cycle(1'b0, 4'b0000, 3'b000, -1, -1);
        check("dp_idle_valid", 64'(seen4.valid), 64'(1'b0));

        // Reset mid-stream: grant 2, reset drops it, first grant after is 0.
        cycle(1'b0, 4'b0100, 3'b000, 2, -1);
        cycle(1'b1, 4'b0100, 3'b000, -1, -1);
        cycle(1'b0, 4'b0101, 3'b000, 0, -1);
        check("post_reset_valid", 64'(seen4.valid), 64'(1'b0));

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 60; i++) begin
            cycle(($urandom_range(0, 19) == 0), 4'($urandom), 3'($urandom), -2, -2);
        end
        cycle(1'b0, 4'b0000, 3'b000, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
